// File: rtl/pe_row_sched.sv
// Control sequencer for one row of chained PEs: clear, stream MAC beats, drain psums, signal done.
// Job configuration (mode, ReLU, length) is captured when a start is accepted.
module pe_row_sched #(
  parameter int NUM_PE = 8,
  parameter int LEN_W  = 16,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_mode,
  input  logic             i_relu_en,
  input  logic [LEN_W-1:0] i_mac_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [1:0]       o_pe_mode,
  output logic             o_reg_clear,
  output logic             o_pe_en,
  output logic             o_psum_out_en,
  output logic             o_relu_en,
  output logic             o_out_valid,
  output logic [IDX_W-1:0] o_out_idx,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           state, state_next;
  logic [1:0]       mode_q;
  logic             relu_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [IDX_W-1:0] drain_cnt;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides every transition out of a busy state, including the final MAC beat.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_start) state_next = S_CLEAR;
      S_CLEAR: state_next = (len_q == '0) ? S_DRAIN : S_MAC;
      S_MAC:   if (i_in_valid && (beat_cnt == len_q - LEN_W'(1))) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == IDX_W'(NUM_PE - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (i_abort && (state != S_IDLE)) state_next = S_ABORT;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      mode_q    <= '0;
      relu_q    <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && i_start) begin
        mode_q <= i_mode;
        relu_q <= i_relu_en;
        len_q  <= i_mac_len;
      end
      if (state == S_CLEAR) begin
        beat_cnt <= '0;
      end else if ((state == S_MAC) && i_in_valid) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if ((state != S_DRAIN) && (state_next == S_DRAIN)) begin
        drain_cnt <= '0;
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + IDX_W'(1);
      end
    end
  end

  // Only o_pe_en looks at an input directly, so stalled beats freeze the PEs in the same cycle.
  always_comb begin
    o_in_ready    = 1'b0;
    o_reg_clear   = 1'b0;
    o_pe_en       = 1'b0;
    o_psum_out_en = 1'b0;
    o_relu_en     = 1'b0;
    o_out_valid   = 1'b0;
    o_out_idx     = '0;
    o_done        = 1'b0;
    o_busy        = (state != S_IDLE);
    o_pe_mode     = mode_q;
    case (state)
      S_CLEAR, S_ABORT: o_reg_clear = 1'b1;
      S_MAC: begin
        o_in_ready = 1'b1;
        o_pe_en    = i_in_valid;
      end
      S_DRAIN: begin
        o_psum_out_en = 1'b1;
        o_out_valid   = 1'b1;
        o_relu_en     = relu_q;
        o_out_idx     = drain_cnt;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_row_sched.sv
// Bench for pe_row_sched: each job pushes its expected control events into a queue,
// and a negedge monitor pops and compares them as the scheduler raises its outputs.
module tb_pe_row_sched;

  localparam int NP    = 4;
  localparam int LEN_W = 16;
  localparam int IDX_W = 2;

  logic             i_clk = 1'b0;
  logic             i_nrst = 1'b0;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic [1:0]       i_mode = '0;
  logic             i_relu_en = 1'b0;
  logic [LEN_W-1:0] i_mac_len = '0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [1:0]       o_pe_mode;
  logic             o_reg_clear;
  logic             o_pe_en;
  logic             o_psum_out_en;
  logic             o_relu_en;
  logic             o_out_valid;
  logic [IDX_W-1:0] o_out_idx;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] sb_q[$];

  pe_row_sched #(.NUM_PE(NP), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_relu_en(i_relu_en), .i_mac_len(i_mac_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_pe_mode(o_pe_mode),
    .o_reg_clear(o_reg_clear), .o_pe_en(o_pe_en), .o_psum_out_en(o_psum_out_en),
    .o_relu_en(o_relu_en), .o_out_valid(o_out_valid), .o_out_idx(o_out_idx),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] packEvt(input int c, input logic clr, input logic pe,
                                          input logic outv, input logic dn, input logic [7:0] idx,
                                          input logic relu, input logic [1:0] mode, input logic busy);
    return {32'(c), 16'h0, clr, pe, outv, dn, idx, relu, mode, busy};
  endfunction

  function automatic bit vAt(input logic [31:0] p, input int k);
    if (k < 0 || k > 31) return 1'b1;
    return p[k];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Every cycle with a visible control action must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_nrst) begin
      checkOutput("invariants",
                  {60'h0, ($countones({o_reg_clear, o_pe_en, o_psum_out_en}) > 1),
                   (o_psum_out_en != o_out_valid), (o_relu_en && !o_out_valid),
                   (o_pe_en && !o_in_ready)}, 64'h0);
      if (o_reg_clear || o_pe_en || o_out_valid || o_done) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_event", 64'h1, 64'h0);
        end else begin
          checkOutput("event",
                      packEvt(cyc, o_reg_clear, o_pe_en, o_out_valid, o_done,
                              o_out_valid ? 8'(o_out_idx) : 8'h0, o_relu_en, o_pe_mode, o_busy),
                      sb_q.pop_front());
        end
      end
    end
  end

  // Builds the expected event schedule for one job, then drives it cycle by cycle.
  task automatic applyStimulus(input int len, input logic [1:0] mode, input logic relu,
                               input logic [31:0] vpat, input int abortOff, input bit startBusy);
    int t, c, endc, beats;
    bit aborted;
    t = cyc;
    aborted = 0;
    endc = t;
    c = t + 1;
    sb_q.push_back(packEvt(c, 1, 0, 0, 0, 8'h0, 0, mode, 1));
    if (abortOff == 1) begin
      sb_q.push_back(packEvt(c + 1, 1, 0, 0, 0, 8'h0, 0, mode, 1));
      endc = c + 1;
      aborted = 1;
    end
    c = t + 2;
    beats = 0;
    for (int g = 0; g < 64 && beats < len && !aborted; g++) begin
      if (vAt(vpat, c - (t + 2))) sb_q.push_back(packEvt(c, 0, 1, 0, 0, 8'h0, 0, mode, 1));
      if (c == t + abortOff) begin
        sb_q.push_back(packEvt(c + 1, 1, 0, 0, 0, 8'h0, 0, mode, 1));
        endc = c + 1;
        aborted = 1;
      end else begin
        if (vAt(vpat, c - (t + 2))) beats++;
        c++;
      end
    end
    for (int i = 0; i < NP && !aborted; i++) begin
      sb_q.push_back(packEvt(c, 0, 0, 1, 0, 8'(i), relu, mode, 1));
      if (c == t + abortOff) begin
        sb_q.push_back(packEvt(c + 1, 1, 0, 0, 0, 8'h0, 0, mode, 1));
        endc = c + 1;
        aborted = 1;
      end else begin
        c++;
      end
    end
    if (!aborted) begin
      sb_q.push_back(packEvt(c, 0, 0, 0, 1, 8'h0, 0, mode, 1));
      endc = c;
    end
    for (int k = t; k <= endc; k++) begin
      i_start    = (k == t) || (startBusy && k > t);
      i_abort    = (k == t + abortOff);
      i_in_valid = vAt(vpat, k - (t + 2));
      if (k == t) begin
        i_mode    = mode;
        i_relu_en = relu;
        i_mac_len = LEN_W'(len);
      end else begin
        i_mode    = 2'($urandom);
        i_relu_en = 1'($urandom);
        i_mac_len = LEN_W'($urandom);
      end
      tick();
    end
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_in_valid = 1'b0;
    checkOutput("idle_after_job", {62'h0, o_busy, o_done}, 64'h0);
    tick();
  endtask

  task automatic resetMidJob();
    int t;
    t = cyc;
    sb_q.push_back(packEvt(t + 1, 1, 0, 0, 0, 8'h0, 0, 2'd3, 1));
    sb_q.push_back(packEvt(t + 2, 0, 1, 0, 0, 8'h0, 0, 2'd3, 1));
    i_start = 1'b1; i_mode = 2'd3; i_relu_en = 1'b1; i_mac_len = 16'd5; i_in_valid = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_nrst = 1'b0;
    #1;
    checkOutput("reset_mid_mac",
                {44'h0, o_in_ready, o_pe_mode, o_reg_clear, o_pe_en, o_psum_out_en,
                 o_relu_en, o_out_valid, 8'(o_out_idx), o_busy, o_done}, 64'h0);
    sb_q.delete();
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    i_in_valid = 1'b0;
    tick();
    checkOutput("idle_after_reset", {63'h0, o_busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #3;
    checkOutput("reset_outputs",
                {44'h0, o_in_ready, o_pe_mode, o_reg_clear, o_pe_en, o_psum_out_en,
                 o_relu_en, o_out_valid, 8'(o_out_idx), o_busy, o_done}, 64'h0);
    tick();
    tick();
    i_nrst = 1'b1;
    tick();
    $display("[TB] stall-free job, len 3");
    applyStimulus(3, 2'd1, 1'b0, 32'hFFFF_FFFF, -1, 0);
    $display("[TB] stalled job, valid 1,0,0,1,1");
    applyStimulus(3, 2'd3, 1'b0, 32'hFFFF_FFF9, -1, 0);
    $display("[TB] empty job, len 0");
    applyStimulus(0, 2'd0, 1'b1, 32'hFFFF_FFFF, -1, 0);
    $display("[TB] abort during drain idx 1");
    applyStimulus(2, 2'd1, 1'b1, 32'hFFFF_FFFF, 5, 0);
    $display("[TB] abort on last MAC beat");
    applyStimulus(2, 2'd2, 1'b0, 32'hFFFF_FFFF, 3, 0);
    $display("[TB] abort in CLEAR");
    applyStimulus(4, 2'd3, 1'b1, 32'hFFFF_FFFF, 1, 0);
    $display("[TB] start and abort together in IDLE");
    applyStimulus(1, 2'd1, 1'b0, 32'hFFFF_FFFF, 0, 0);
    $display("[TB] start held while busy and during done");
    applyStimulus(2, 2'd1, 1'b0, 32'hFFFF_FFFA, -1, 1);
    $display("[TB] new job latches mode 2 and relu 1");
    applyStimulus(2, 2'd2, 1'b1, 32'hFFFF_FFFF, -1, 0);
    $display("[TB] reset mid-MAC then clean job");
    resetMidJob();
    applyStimulus(3, 2'd1, 1'b0, 32'hFFFF_FFFF, -1, 0);
    tick();
    tick();
    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
